// File: rtl/fm_pkg.sv
// fm_pkg: shared types and constants for the NCO-based FM modulator.
// State codes, reset carrier step, dither LFSR polynomial/seed and dither width.
package fm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT     = 2'd1,
        ST_RUN      = 2'd2,
        ST_UNDERRUN = 2'd3
    } fm_state_e;

    // 90 MHz carrier at a 250 MHz clock
    localparam logic [31:0] FM_CARRIER_DEFAULT = 32'h5C28_F5C2;

    // Galois form (right shift) of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam int          DITHER_W  = 8;

endpackage

// File: rtl/fm_lfsr.sv
// fm_lfsr: 16-bit Galois LFSR producing phase dither for the FM modulator.
// Only instantiated when FM_DITHER_EN is defined.
module fm_lfsr
    import fm_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_adv,
    output logic [DITHER_W-1:0] o_dither
);

    logic [15:0] lfsr_q, lfsr_d;

    // Advance one step per cycle while enabled, otherwise hold
    always_comb begin
        lfsr_d = lfsr_q;
        if (i_adv) lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);
    end

    // State register, reloads the seed on reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) lfsr_q <= LFSR_SEED;
        else          lfsr_q <= lfsr_d;
    end

    assign o_dither = lfsr_q[DITHER_W-1:0];

endmodule

// File: rtl/fm_nco_modulator.sv
// fm_nco_modulator: NCO-based FM modulator with valid/ready sample input,
// programmable carrier, enable/mute, underrun timeout with sticky flag.
// Optional phase dither is built in when the macro FM_DITHER_EN is defined.
module fm_nco_modulator
    import fm_pkg::*;
#(
    parameter int                 PHASE_W         = 32,
    parameter int                 SAMPLE_W        = 8,
    parameter int                 DEV_SHIFT       = 13,
    parameter int                 TIMEOUT_W       = 16,
    parameter int                 OUT_BITS        = 4,
    parameter logic [PHASE_W-1:0] CARRIER_DEFAULT = PHASE_W'(FM_CARRIER_DEFAULT)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic [PHASE_W-1:0]   i_carrier_step,
    input  logic                 i_carrier_load,
    input  logic [SAMPLE_W-1:0]  i_sample,
    input  logic                 i_sample_vld,
    output logic                 o_sample_rdy,
    input  logic [TIMEOUT_W-1:0] i_timeout,
    input  logic                 i_clr_underrun,
    output logic                 o_underrun,
    output logic [1:0]           o_state,
    output logic                 o_rf,
    output logic [OUT_BITS-1:0]  o_phase
);

    if (SAMPLE_W + DEV_SHIFT > PHASE_W) begin : g_bad_cfg
        $error("fm_nco_modulator: SAMPLE_W + DEV_SHIFT exceeds PHASE_W");
    end

    fm_state_e             state_q, state_d;
    logic                  rdy_q, underrun_q, underrun_d, rf_q;
    logic [OUT_BITS-1:0]   ophase_q;
    logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
    logic [SAMPLE_W-1:0]   sample_q, sample_d;
    logic [PHASE_W-1:0]    step_q, step_d, carrier_q, carrier_d, phase_q, phase_d;
    logic [PHASE_W-1:0]    dev, inc;
    logic signed [SAMPLE_W-1:0] sample_s;
    logic                  accept, expire;

    assign accept   = i_sample_vld & rdy_q;
    assign sample_s = sample_q;
    assign dev      = PHASE_W'(sample_s) <<< DEV_SHIFT;

`ifdef FM_DITHER_EN
    logic [DITHER_W-1:0] dither;

    fm_lfsr u_lfsr (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_adv    (state_q != ST_IDLE),
        .o_dither (dither)
    );

    assign inc = step_q + PHASE_W'(dither);
`else
    assign inc = step_q;
`endif

    // Next state; enable low overrides everything, accept beats timeout expiry
    always_comb begin
        state_d = state_q;
        expire  = 1'b0;
        if (!i_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:     state_d = ST_WAIT;
                ST_WAIT:     if (accept) state_d = ST_RUN;
                ST_RUN: begin
                    if (!accept && i_timeout != '0 &&
                        cnt_q == i_timeout - TIMEOUT_W'(1)) begin
                        state_d = ST_UNDERRUN;
                        expire  = 1'b1;
                    end
                end
                ST_UNDERRUN: if (accept) state_d = ST_RUN;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath next values: sample capture, step = carrier + deviation, phase accumulate
    always_comb begin
        sample_d   = sample_q;
        cnt_d      = '0;
        step_d     = '0;
        phase_d    = '0;
        carrier_d  = i_carrier_load ? i_carrier_step : carrier_q;
        underrun_d = expire ? 1'b1 : (i_clr_underrun ? 1'b0 : underrun_q);
        if (accept)      sample_d = i_sample;
        else if (expire) sample_d = '0;
        if (state_q == ST_RUN && state_d == ST_RUN && !accept)
            cnt_d = cnt_q + TIMEOUT_W'(1);
        if (state_d != ST_IDLE) begin
            // deviation only once a sample has reached sample_q in RUN/UNDERRUN
            step_d  = carrier_q + ((state_q == ST_RUN || state_q == ST_UNDERRUN) ? dev : '0);
            phase_d = phase_q + inc;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            rdy_q      <= 1'b0;
            underrun_q <= 1'b0;
            cnt_q      <= '0;
            sample_q   <= '0;
            step_q     <= '0;
            carrier_q  <= CARRIER_DEFAULT;
            phase_q    <= '0;
            rf_q       <= 1'b0;
            ophase_q   <= '0;
        end else begin
            state_q    <= state_d;
            rdy_q      <= (state_d != ST_IDLE);
            underrun_q <= underrun_d;
            cnt_q      <= cnt_d;
            sample_q   <= sample_d;
            step_q     <= step_d;
            carrier_q  <= carrier_d;
            phase_q    <= phase_d;
            rf_q       <= (state_d != ST_IDLE) ? phase_q[PHASE_W-1] : 1'b0;
            ophase_q   <= (state_d != ST_IDLE) ? phase_q[PHASE_W-1 -: OUT_BITS] : '0;
        end
    end

    assign o_sample_rdy = rdy_q;
    assign o_underrun   = underrun_q;
    assign o_state      = state_q;
    assign o_rf         = rf_q;
    assign o_phase      = ophase_q;

endmodule

// File: tb/tb_fm_nco_modulator.sv
// tb_fm_nco_modulator: directed plus randomized bench for fm_nco_modulator,
// checked every cycle against a behavioural model of the modulator.
module tb_fm_nco_modulator;

    localparam logic [31:0] CAR = 32'h5C28_F5C2;

    logic        i_clk, i_rst_n, i_en, i_carrier_load, i_sample_vld, i_clr_underrun;
    logic [31:0] i_carrier_step;
    logic [7:0]  i_sample;
    logic [15:0] i_timeout;
    logic        o_sample_rdy, o_underrun, o_rf;
    logic [1:0]  o_state;
    logic [3:0]  o_phase;

    int checks   = 0;
    int failures = 0;

    fm_nco_modulator dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_en           (i_en),
        .i_carrier_step (i_carrier_step),
        .i_carrier_load (i_carrier_load),
        .i_sample       (i_sample),
        .i_sample_vld   (i_sample_vld),
        .o_sample_rdy   (o_sample_rdy),
        .i_timeout      (i_timeout),
        .i_clr_underrun (i_clr_underrun),
        .o_underrun     (o_underrun),
        .o_state        (o_state),
        .o_rf           (o_rf),
        .o_phase        (o_phase)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- behavioural model ----------------
    int        m_st;        // 0 idle, 1 wait, 2 run, 3 underrun
    int        m_quiet;     // sample-free RUN cycles since last accept
    bit        m_rdy, m_flag, m_rf;
    bit [3:0]  m_oph;
    bit [7:0]  m_samp;
    bit [31:0] m_car, m_step, m_phase;
    bit [15:0] m_lfsr;

    function automatic bit [31:0] dev_of(input bit [7:0] s);
        int v;
        v = $signed(s);
        return 32'(v * 8192);
    endfunction

    task automatic model_reset();
        m_st = 0; m_quiet = 0; m_rdy = 0; m_flag = 0; m_rf = 0; m_oph = 0;
        m_samp = 0; m_car = CAR; m_step = 0; m_phase = 0; m_lfsr = 16'hACE1;
    endtask

    task automatic model_step();
        bit acc, expire;
        int nst;
        bit [31:0] add;
        if (!i_rst_n) begin
            model_reset();
            return;
        end
        acc = i_sample_vld && m_rdy;
        expire = 0;
        if (!i_en)                 nst = 0;
        else if (m_st == 0)        nst = 1;
        else if (acc)              nst = 2;
        else if (m_st == 2 && i_timeout != 0 && m_quiet + 1 == int'(i_timeout)) begin
            nst = 3; expire = 1;
        end else                   nst = m_st;
        add = 0;
`ifdef FM_DITHER_EN
        add = {24'd0, m_lfsr[7:0]};
        if (m_st != 0) m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
`endif
        m_rf    = (nst == 0) ? 1'b0 : m_phase[31];
        m_oph   = (nst == 0) ? 4'h0 : m_phase[31:28];
        m_phase = (nst == 0) ? 32'd0 : m_phase + m_step + add;
        m_step  = (nst == 0) ? 32'd0 : m_car + ((m_st >= 2) ? dev_of(m_samp) : 32'd0);
        if (acc)         m_samp = i_sample;
        else if (expire) m_samp = 0;
        if (i_carrier_load) m_car = i_carrier_step;
        if (expire)              m_flag = 1;
        else if (i_clr_underrun) m_flag = 0;
        m_quiet = (nst == 2 && m_st == 2 && !acc) ? m_quiet + 1 : 0;
        m_rdy   = (nst != 0);
        m_st    = nst;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: advance model with the inputs seen at the edge, then compare
    task automatic tick();
        @(posedge i_clk);
        model_step();
        #1;
        chk("state",    64'(o_state),      64'(m_st));
        chk("rdy",      64'(o_sample_rdy), 64'(m_rdy));
        chk("underrun", 64'(o_underrun),   64'(m_flag));
        chk("rf",       64'(o_rf),         64'(m_rf));
        chk("phase",    64'(o_phase),      64'(m_oph));
        chk("step",     64'(dut.step_q),   64'(m_step));
    endtask

    task automatic accept(input bit [7:0] s);
        i_sample = s; i_sample_vld = 1'b1;
        tick();
        i_sample_vld = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] p0, d;
        int rises;
        bit prev_rf;

        i_rst_n = 0; i_en = 0; i_carrier_step = 0; i_carrier_load = 0;
        i_sample = 0; i_sample_vld = 0; i_timeout = 0; i_clr_underrun = 0;
        model_reset();
        repeat (3) tick();
        chk("rst_state", 64'(o_state), 0);
        chk("rst_rdy",   64'(o_sample_rdy), 0);
        chk("rst_flag",  64'(o_underrun), 0);
        chk("rst_rf",    64'(o_rf), 0);
        chk("rst_phase", 64'(o_phase), 0);

        // enable, no samples: unmodulated carrier
        i_rst_n = 1; i_en = 1;
        tick();
        chk("wait_state", 64'(o_state), 1);
        chk("wait_rdy",   64'(o_sample_rdy), 1);
        repeat (3) tick();
        chk("wait_step", 64'(dut.step_q), 64'(CAR));
        p0 = dut.phase_q;
        tick();
        d = dut.phase_q - p0;
`ifdef FM_DITHER_EN
        chk("wait_inc_range", 64'(d >= CAR && d <= CAR + 32'd255), 1);
`else
        chk("wait_inc", 64'(d), 64'(CAR));
`endif
        rises = 0; prev_rf = o_rf;
        for (int k = 0; k < 900; k++) begin
            tick();
            if (o_rf && !prev_rf) rises++;
            prev_rf = o_rf;
        end
        chk("rf_rate", 64'(rises >= 321 && rises <= 327), 1);

        // sample deviation latency and sign extension
        accept(8'h01);
        chk("acc1_state", 64'(o_state), 2);
        chk("acc1_step_early", 64'(dut.step_q), 64'(CAR));
        tick();
        chk("acc1_step", 64'(dut.step_q), 64'h5C29_15C2);
        accept(8'h80);
        tick();
        chk("acc80_step", 64'(dut.step_q), 64'h5C18_F5C2);

        // quarter-turn carrier loaded together with a zero sample, then re-enter via IDLE
        i_carrier_step = 32'h4000_0000; i_carrier_load = 1;
        accept(8'h00);
        i_carrier_load = 0; i_en = 0;
        tick();
        chk("endrop_state", 64'(o_state), 0);
        chk("endrop_rf",    64'(o_rf), 0);
        chk("endrop_phase", 64'(o_phase), 0);
        i_en = 1;
        tick();
`ifndef FM_DITHER_EN
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("ld_phase", 64'(o_phase), 64'((k * 4) % 16));
            chk("ld_rf",    64'(o_rf),    64'((k % 4) >= 2));
        end
`endif
        i_carrier_step = CAR; i_carrier_load = 1;
        tick();
        i_carrier_load = 0;

        // underrun after 100 quiet cycles
        i_timeout = 16'd100;
        accept(8'h10);
        chk("to_run", 64'(o_state), 2);
        repeat (99) tick();
        chk("to_run99", 64'(o_state), 2);
        tick();
        chk("to_under", 64'(o_state), 3);
        chk("to_flag",  64'(o_underrun), 1);
        tick();
        chk("to_step_car", 64'(dut.step_q), 64'(CAR));
        accept(8'h05);
        chk("to_rerun", 64'(o_state), 2);
        chk("to_flag_sticky", 64'(o_underrun), 1);
        i_clr_underrun = 1;
        tick();
        i_clr_underrun = 0;
        chk("to_flag_clr", 64'(o_underrun), 0);

        // set and clear in the same cycle: set wins
        i_timeout = 16'd3;
        accept(8'h22);
        i_clr_underrun = 1;
        repeat (2) tick();
        chk("sc_run", 64'(o_state), 2);
        tick();
        i_clr_underrun = 0;
        chk("sc_under", 64'(o_state), 3);
        chk("sc_flag",  64'(o_underrun), 1);

        // accept in the expiry cycle keeps RUN
        accept(8'h33);
        repeat (2) tick();
        accept(8'h44);
        chk("acc_wins", 64'(o_state), 2);

        // reset mid-RUN after loading a non-default carrier
        i_carrier_step = 32'h1234_5678; i_carrier_load = 1;
        tick();
        i_carrier_load = 0; i_rst_n = 0;
        tick();
        chk("mrst_state", 64'(o_state), 0);
        chk("mrst_rdy",   64'(o_sample_rdy), 0);
        chk("mrst_flag",  64'(o_underrun), 0);
        chk("mrst_rf",    64'(o_rf), 0);
        chk("mrst_phase", 64'(o_phase), 0);
        chk("mrst_car",   64'(dut.carrier_q), 64'(CAR));
        i_rst_n = 1;

        // randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            if (k % 500 == 0) i_timeout = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(2, 30));
            i_en           = ($urandom_range(0, 149) != 0);
            i_rst_n        = ($urandom_range(0, 999) != 0);
            i_sample_vld   = ($urandom_range(0, 3) == 0);
            i_sample       = 8'($urandom);
            i_carrier_load = ($urandom_range(0, 49) == 0);
            i_carrier_step = $urandom;
            i_clr_underrun = ($urandom_range(0, 19) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
